// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the UART receive collector.
//   CHAR_BITS  : bit times per character (start + 8 data + stop).
//   entry_t    : one stored entry: error bit plus data byte.
//   make_entry : builds the entry pushed for a receiver event.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int CHAR_BITS = 10;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } entry_t;

  // A pure error event carries no trustworthy byte, so its data is zeroed.
  function automatic entry_t make_entry(input logic       done,
                                        input logic       err,
                                        input logic [7:0] data);
    entry_t e;
    e.err  = err;
    e.data = done ? data : 8'h00;
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_collector_if.sv
// -----------------------------------------------------------------------------
// uart_rx_collector_if
// Groups the receiver-side strobes and the consumer pop handshake.
//   en, rxData, rxDone, rxErr : from the UART receiver (en = oversample strobe)
//   popReq                    : consumer removes the head entry
//   popData, popErr, empty    : head entry and occupancy seen by the consumer
// master : drives receiver strobes and popReq (receiver + consumer side)
// slave  : the collector
// -----------------------------------------------------------------------------
interface uart_rx_collector_if;

  logic       en;
  logic [7:0] rxData;
  logic       rxDone;
  logic       rxErr;
  logic       popReq;
  logic [7:0] popData;
  logic       popErr;
  logic       empty;

  modport master (
    output en, rxData, rxDone, rxErr, popReq,
    input  popData, popErr, empty
  );

  modport slave (
    input  en, rxData, rxDone, rxErr, popReq,
    output popData, popErr, empty
  );

endinterface

// File: rtl/uart_rx_store.sv
// -----------------------------------------------------------------------------
// uart_rx_store
// First-word-fall-through entry storage with wrapping read/write pointers.
// Occupancy flags come from the entry count, never from pointer comparison.
// Ports:
//   clk, sync_reset_i : clock and synchronous active-high reset
//   push_i, pop_i     : already-accepted push / pop for this cycle
//   flush_i           : discard all entries (overrides push/pop)
//   wr_entry_i        : entry written on push
//   head_o            : head entry, zero while empty
//   count_o           : entries held, 0..DEPTH
//   empty_o, full_o   : occupancy flags
// -----------------------------------------------------------------------------
module uart_rx_store
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   sync_reset_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  entry_t                 wr_entry_i,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (sync_reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the entry array is deliberately not reset; stale contents are unreachable
  // because the head is masked to zero whenever the store is empty.
  always_ff @(posedge clk) begin
    if (!sync_reset_i && !flush_i && push_i) begin
      mem_q[wr_ptr_q] <= wr_entry_i;
    end
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_collector.sv
// -----------------------------------------------------------------------------
// uart_rx_collector
// Collects bytes / error events from a UART receiver into a small FWFT store,
// with sticky overrun/underrun flags and an idle-line timeout.
// Ports:
//   clk        : sole clock, rising edge
//   syncReset  : synchronous active-high reset
//   rx_if      : receiver strobes (en, rxData, rxDone, rxErr) and pop handshake
//                (popReq, popData, popErr, empty)
//   flush      : discard all entries and clear all flags
//   clearFlags : clear sticky flags
//   full       : store full
//   count      : entries held, 0..DEPTH
//   overrun    : sticky, a push was dropped because the store was full
//   underrun   : sticky, popReq arrived while empty
//   timeout    : entries have waited TIMEOUT_CHARS character times unread
// -----------------------------------------------------------------------------
module uart_rx_collector
  import uart_rx_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int Oversample    = 16,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                   clk,
  input  logic                   syncReset,
  uart_rx_collector_if.slave     rx_if,
  input  logic                   flush,
  input  logic                   clearFlags,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  output logic                   underrun,
  output logic                   timeout
);

  localparam int TO_LIMIT = TIMEOUT_CHARS * CHAR_BITS * Oversample;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  logic   empty_w, full_w;
  entry_t head_w;
  logic   push_ev, push_ok, pop_ok, ovr_set, udr_set, to_set;

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;
  logic          timeout_q, timeout_d;

  // A pop frees a slot in the same cycle, so a full store still accepts a
  // push alongside an accepted pop. A pop while empty never bypasses a push.
  always_comb begin
    push_ev = rx_if.en && (rx_if.rxDone || rx_if.rxErr);
    pop_ok  = rx_if.popReq && !empty_w;
    push_ok = push_ev && (!full_w || pop_ok);
    ovr_set = push_ev && !push_ok;
    udr_set = rx_if.popReq && empty_w;
  end

  uart_rx_store #(
    .DEPTH (DEPTH)
  ) u_store (
    .clk          (clk),
    .sync_reset_i (syncReset),
    .push_i       (push_ok && !flush),
    .pop_i        (pop_ok && !flush),
    .flush_i      (flush),
    .wr_entry_i   (make_entry(rx_if.rxDone, rx_if.rxErr, rx_if.rxData)),
    .head_o       (head_w),
    .count_o      (count),
    .empty_o      (empty_w),
    .full_o       (full_w)
  );

  // Idle counter: en ticks since the last store activity; saturates so the
  // timeout set event fires only on the transition into the limit.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_set   = 1'b0;
    if (flush || push_ok || pop_ok || empty_w) begin
      to_cnt_d = '0;
    end else if (rx_if.en && to_cnt_q != TW'(TO_LIMIT)) begin
      to_cnt_d = to_cnt_q + TW'(1);
      to_set   = (to_cnt_q == TW'(TO_LIMIT - 1));
    end
  end

  // Later assignments win: flush > set events > push/pop clears > clearFlags.
  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    timeout_d  = timeout_q;
    if (clearFlags) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (push_ok || pop_ok) timeout_d  = 1'b0;
    if (ovr_set)           overrun_d  = 1'b1;
    if (udr_set)           underrun_d = 1'b1;
    if (to_set)            timeout_d  = 1'b1;
    if (flush) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
      timeout_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (syncReset) begin
      to_cnt_q   <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      to_cnt_q   <= to_cnt_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign rx_if.popData = head_w.data;
  assign rx_if.popErr  = head_w.err;
  assign rx_if.empty   = empty_w;
  assign full          = full_w;
  assign overrun       = overrun_q;
  assign underrun      = underrun_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_uart_rx_collector.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_collector
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared every cycle against a queue-based reference model of the collector.
// -----------------------------------------------------------------------------
module tb_uart_rx_collector;
  import uart_rx_pkg::*;

  localparam int DEPTH    = 8;
  localparam int TO_LIMIT = 4 * 10 * 16;

  logic       clk = 1'b0;
  logic       syncReset;
  logic       flush;
  logic       clearFlags;
  logic       full;
  logic [3:0] count;
  logic       overrun, underrun, timeout;

  uart_rx_collector_if rx_if ();

  uart_rx_collector #(
    .DEPTH         (DEPTH),
    .Oversample    (16),
    .TIMEOUT_CHARS (4)
  ) dut (
    .clk        (clk),
    .syncReset  (syncReset),
    .rx_if      (rx_if),
    .flush      (flush),
    .clearFlags (clearFlags),
    .full       (full),
    .count      (count),
    .overrun    (overrun),
    .underrun   (underrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: stored entries plus flags and idle-tick age.
  entry_t mq[$];
  bit     m_ovr, m_udr, m_to;
  int     m_idle;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic i_en, input logic i_done, input logic i_err,
                       input logic [7:0] i_data, input logic i_pop,
                       input logic i_flush, input logic i_clr, input logic i_rst);
    bit was_empty, push, pop_ok, push_ok;
    entry_t e;
    if (i_rst || i_flush) begin
      mq.delete();
      m_ovr = 0; m_udr = 0; m_to = 0; m_idle = 0;
      return;
    end
    was_empty = (mq.size() == 0);
    push      = i_en && (i_done || i_err);
    pop_ok    = i_pop && !was_empty;
    push_ok   = push && (mq.size() < DEPTH || pop_ok);
    if (i_clr) begin m_ovr = 0; m_udr = 0; m_to = 0; end
    if (push_ok || pop_ok) m_to = 0;
    if (push && !push_ok) m_ovr = 1;
    if (i_pop && was_empty) m_udr = 1;
    if (pop_ok) void'(mq.pop_front());
    if (push_ok) begin
      e.err  = i_err;
      e.data = i_done ? i_data : 8'h00;
      mq.push_back(e);
    end
    if (push_ok || pop_ok || was_empty) begin
      m_idle = 0;
    end else if (i_en && m_idle < TO_LIMIT) begin
      m_idle++;
      if (m_idle == TO_LIMIT) m_to = 1;
    end
  endtask

  task automatic compare_all();
    int n = mq.size();
    check("count",    32'(count),         32'(n));
    check("empty",    32'(rx_if.empty),   32'(n == 0));
    check("full",     32'(full),          32'(n == DEPTH));
    check("popData",  32'(rx_if.popData), (n > 0) ? 32'(mq[0].data) : 32'h0);
    check("popErr",   32'(rx_if.popErr),  (n > 0) ? 32'(mq[0].err)  : 32'h0);
    check("overrun",  32'(overrun),       32'(m_ovr));
    check("underrun", 32'(underrun),      32'(m_udr));
    check("timeout",  32'(timeout),       32'(m_to));
  endtask

  // Drive one cycle of inputs (we sit just after a falling edge), advance the
  // model, let the DUT clock, then compare on the next falling edge.
  task automatic step(input logic i_en, input logic i_done, input logic i_err,
                      input logic [7:0] i_data, input logic i_pop,
                      input logic i_flush, input logic i_clr, input logic i_rst);
    rx_if.en     = i_en;
    rx_if.rxDone = i_done;
    rx_if.rxErr  = i_err;
    rx_if.rxData = i_data;
    rx_if.popReq = i_pop;
    flush        = i_flush;
    clearFlags   = i_clr;
    syncReset    = i_rst;
    model(i_en, i_done, i_err, i_data, i_pop, i_flush, i_clr, i_rst);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic push_byte(input logic [7:0] d);
    step(1'b1, 1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_flags();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(rx_if.empty), 32'd1);
    check("rst_flags", {29'd0, overrun, underrun, timeout}, 32'd0);
    check("rst_popData", 32'(rx_if.popData), 32'd0);

    // Two bytes in, two out, FWFT order
    push_byte(8'h41);
    check("two_c1", 32'(count), 32'd1);
    push_byte(8'h42);
    check("two_c2", 32'(count), 32'd2);
    check("two_head0", 32'(rx_if.popData), 32'h41);
    pop_one();
    check("two_head1", 32'(rx_if.popData), 32'h42);
    check("two_c1b", 32'(count), 32'd1);
    pop_one();
    check("two_empty", 32'(rx_if.empty), 32'd1);

    // Overfill: ninth push dropped, overrun set, bytes 1..8 in order
    for (int i = 1; i <= 9; i++) begin
      push_byte(8'(i));
      if (i == 8) check("ovf_full", 32'(full), 32'd1);
    end
    check("ovf_overrun", 32'(overrun), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_order", 32'(rx_if.popData), 32'(i));
      pop_one();
    end
    clear_flags();
    check("clr_overrun", 32'(overrun), 32'd0);

    // Full store with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    step(1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sim_count", 32'(count), 32'd8);
    check("sim_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 7; i++) pop_one();
    check("sim_last", 32'(rx_if.popData), 32'h55);
    do_flush();
    check("flush_empty", 32'(rx_if.empty), 32'd1);

    // Timeout exactly TO_LIMIT en ticks after the push
    push_byte(8'h77);
    for (int i = 1; i <= TO_LIMIT; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == TO_LIMIT - 1) check("to_before", 32'(timeout), 32'd0);
    end
    check("to_at", 32'(timeout), 32'd1);
    pop_one();
    check("to_popclr", 32'(timeout), 32'd0);

    // Error-only entry, underrun, clearFlags
    step(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("err_bit", 32'(rx_if.popErr), 32'd1);
    check("err_data", 32'(rx_if.popData), 32'h00);
    pop_one();
    pop_one();
    check("udr_set", 32'(underrun), 32'd1);
    // Underrun set coincident with clearFlags stays set
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    check("udr_coinc", 32'(underrun), 32'd1);
    clear_flags();
    check("clr_all", {29'd0, overrun, underrun, timeout}, 32'd0);

    // Reset with 5 entries and overrun set
    for (int i = 0; i < 9; i++) push_byte(8'hC0 + 8'(i));
    for (int i = 0; i < 3; i++) pop_one();
    check("pre_rst_count", 32'(count), 32'd5);
    check("pre_rst_ovr", 32'(overrun), 32'd1);
    step(1'b1, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst5_count", 32'(count), 32'd0);
    check("rst5_empty", 32'(rx_if.empty), 32'd1);
    check("rst5_flags", {29'd0, overrun, underrun, timeout}, 32'd0);

    // Randomized traffic, alternating fill-biased and drain-biased phases
    for (int c = 0; c < 4000; c++) begin
      logic r_en, r_done, r_err, r_pop, r_fl, r_clr, r_rst;
      logic [7:0] r_data;
      bit drain;
      drain  = ((c / 400) % 2) == 1;
      r_en   = 1'($urandom_range(0, 1));
      r_done = ($urandom_range(0, 2) == 0);
      r_err  = ($urandom_range(0, 7) == 0);
      r_data = 8'($urandom);
      r_pop  = drain ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      r_fl   = ($urandom_range(0, 99) == 0);
      r_clr  = ($urandom_range(0, 31) == 0);
      r_rst  = ($urandom_range(0, 299) == 0);
      step(r_en, r_done, r_err, r_data, r_pop, r_fl, r_clr, r_rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
